// File: rtl/mac_operand_sequencer.sv
// Operand-pair buffer and issue sequencer feeding the fp8 MAC stage; captures one dot product per vector.
// Optional build macro MAC_ZERO_SKIP_EN: pairs with a +/-0 operand are not issued to the MAC.
`timescale 1ns/1ps

// state   | meaning
// IDLE    | accept operand writes, wait for start
// CLR     | pulse mac_clr to zero the MAC accumulator
// ISSUE   | present buffer[idx], mac_st high unless the pair is skipped
// WAIT_LO | wait for mac_done low (discard a held-over done level)
// WAIT_HI | wait for mac_done high (MAC latency)
// DROP    | mac_st low for one cycle, advance or finish
// FIN     | vec_done pulse and vec_result valid, release buffer
module mac_operand_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_b,
  input  logic [7:0]    wr_c,
  input  logic          start,
  input  logic [7:0]    mac_result,
  input  logic          mac_done,
  output logic [7:0]    mac_b,
  output logic [7:0]    mac_c,
  output logic          mac_st,
  output logic          mac_clr,
  output logic          busy,
  output logic [AW:0]   count,
  output logic          full,
  output logic          vec_done,
  output logic [7:0]    vec_result
);

  typedef enum logic [2:0] {
    IDLE, CLR, ISSUE, WAIT_LO, WAIT_HI, DROP, FIN
  } seqStateT;

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  seqStateT      state;
  logic [15:0]   pairMem [DEPTH];
  logic [AW-1:0] idx;
  logic [AW-1:0] issueIdx;
  logic [15:0]   issuePair;
  logic          skipPair;
  logic          lastPair;
  logic          wrAccept;

  assign full      = (count == FullCount);
  assign wrAccept  = (state == IDLE) && wr_en && !start && !full;
  // the pair about to be presented: first entry from CLR, next entry from DROP
  assign issueIdx  = (state == DROP) ? idx + AW'(1) : '0;
  assign issuePair = pairMem[issueIdx];
  assign lastPair  = (({1'b0, idx} + (AW+1)'(1)) == count);

`ifdef MAC_ZERO_SKIP_EN
  assign skipPair = (issuePair[14:8] == 7'd0) || (issuePair[6:0] == 7'd0);
`else
  assign skipPair = 1'b0;
`endif

  // buffer contents survive FIN and reset; only count tracks validity
  always_ff @(posedge clk) begin
    if (wrAccept) pairMem[count[AW-1:0]] <= {wr_b, wr_c};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      count      <= '0;
      mac_b      <= 8'h00;
      mac_c      <= 8'h00;
      mac_st     <= 1'b0;
      mac_clr    <= 1'b0;
      busy       <= 1'b0;
      vec_done   <= 1'b0;
      vec_result <= 8'h00;
    end else begin
      mac_clr  <= 1'b0;
      vec_done <= 1'b0;
      if (wrAccept) count <= count + (AW+1)'(1);
      case (state)
        IDLE: begin
          if (start) begin
            idx <= '0;
            if (count == '0) begin
              vec_result <= 8'h00;
              vec_done   <= 1'b1;
              state      <= FIN;
            end else begin
              busy    <= 1'b1;
              mac_clr <= 1'b1;
              state   <= CLR;
            end
          end
        end
        CLR: begin
          mac_b  <= issuePair[15:8];
          mac_c  <= issuePair[7:0];
          mac_st <= !skipPair;
          state  <= ISSUE;
        end
        // mac_st is low here only for a skipped pair
        ISSUE: state <= mac_st ? WAIT_LO : DROP;
        WAIT_LO: begin
          if (!mac_done) state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (mac_done) begin
            mac_st <= 1'b0;
            state  <= DROP;
          end
        end
        DROP: begin
          if (lastPair) begin
            vec_result <= mac_result;
            vec_done   <= 1'b1;
            state      <= FIN;
          end else begin
            idx    <= idx + AW'(1);
            mac_b  <= issuePair[15:8];
            mac_c  <= issuePair[7:0];
            mac_st <= !skipPair;
            state  <= ISSUE;
          end
        end
        FIN: begin
          count <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed and randomized bench for mac_operand_sequencer with a behavioural fp8 MAC responder.
`timescale 1ns/1ps

module tb_mac_operand_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_b = 8'h00;
  logic [7:0]    wr_c = 8'h00;
  logic          start = 1'b0;
  logic [7:0]    mac_result;
  logic          mac_done;
  logic [7:0]    mac_b, mac_c;
  logic          mac_st, mac_clr, busy, full, vec_done;
  logic [AW:0]   count;
  logic [7:0]    vec_result;

  mac_operand_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_b(wr_b), .wr_c(wr_c), .start(start),
    .mac_result(mac_result), .mac_done(mac_done), .mac_b(mac_b), .mac_c(mac_c),
    .mac_st(mac_st), .mac_clr(mac_clr), .busy(busy), .count(count), .full(full),
    .vec_done(vec_done), .vec_result(vec_result)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // fp8: 1 sign, 4 exponent (bias 7), 3 mantissa
  function automatic real fp8Val(input logic [7:0] x);
    int  e;
    real m;
    real mag;
    e = int'(x[6:3]);
    m = real'(x[2:0]);
    if (e == 0) mag = m / 8.0 / 64.0;
    else begin
      mag = 1.0 + m / 8.0;
      for (int i = 7; i < e; i++) mag = mag * 2.0;
      for (int i = e; i < 7; i++) mag = mag / 2.0;
    end
    return x[7] ? -mag : mag;
  endfunction

  function automatic logic [7:0] fp8Enc(input real v);
    logic s;
    real  a;
    int   e;
    int   m;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 7;
    if (a == 0.0) return 8'h00;
    while (a >= 2.0 && e < 40) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > -40) begin a = a * 2.0; e--; end
    if (e > 15) return {s, 7'h7F};
    if (e < 1) return 8'h00;
    m = $rtoi((a - 1.0) * 8.0);
    return {s, 4'(e), 3'(m)};
  endfunction

  function automatic bit isSkip(input logic [15:0] p);
`ifdef MAC_ZERO_SKIP_EN
    return (p[14:8] == 7'd0) || (p[6:0] == 7'd0);
`else
    return (p == 16'h0) && 1'b0;
`endif
  endfunction

  function automatic logic [7:0] randOp(input bit allowZero);
    if (allowZero && $urandom_range(0, 4) == 0)
      return ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00;
    return {1'($urandom_range(0, 1)), 4'($urandom_range(5, 9)), 3'($urandom_range(0, 7))};
  endfunction

  // MAC responder: done drops on a new start, rises after 2..4 cycles, drops when mac_st falls
  logic       modelDone = 1'b0;
  logic [7:0] modelResult = 8'h00;
  real        acc = 0.0;
  int         lat = 0;
  bit         pending = 1'b0;
  bit         forceHi = 1'b0;
  bit         forceLo = 1'b0;
  logic       stPrev = 1'b0;
  int         rises = 0;
  int         clrCycles = 0;
  int         vecDones = 0;
  logic [7:0] lastVec = 8'h00;
  logic [15:0] issuedQ[$];

  assign mac_done   = forceHi ? 1'b1 : (forceLo ? 1'b0 : modelDone);
  assign mac_result = modelResult;

  always @(negedge clk) begin
    if (!rst_n) begin
      modelDone   = 1'b0;
      modelResult = 8'h00;
      acc         = 0.0;
      pending     = 1'b0;
      stPrev      = 1'b0;
    end else begin
      if (mac_clr) begin
        acc         = 0.0;
        modelResult = 8'h00;
        clrCycles++;
      end
      if (mac_st && !stPrev) begin
        rises++;
        issuedQ.push_back({mac_b, mac_c});
        modelDone = 1'b0;
        pending   = 1'b1;
        lat       = int'($urandom_range(2, 4));
      end else if (pending && !forceHi && !forceLo) begin
        lat--;
        if (lat == 0) begin
          acc         = acc + fp8Val(mac_b) * fp8Val(mac_c);
          modelResult = fp8Enc(acc);
          modelDone   = 1'b1;
          pending     = 1'b0;
        end
      end else if (!mac_st) begin
        modelDone = 1'b0;
      end
      stPrev = mac_st;
      if (vec_done) begin
        vecDones++;
        lastVec = vec_result;
      end
    end
  end

  logic [15:0] refQ[$];
  int rises0, clr0, done0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic writePair(input logic [7:0] b, input logic [7:0] c);
    wr_en = 1'b1;
    wr_b  = b;
    wr_c  = c;
    tick(1);
    wr_en = 1'b0;
    if (refQ.size() < DEPTH) refQ.push_back({b, c});
  endtask

  task automatic startVec(input bit withWrite);
    rises0 = rises;
    clr0   = clrCycles;
    done0  = vecDones;
    issuedQ.delete();
    if (withWrite) begin
      wr_en = 1'b1;
      wr_b  = 8'h55;
      wr_c  = 8'h66;
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic finishVec(input string tag);
    int          guard;
    real         sum;
    logic [7:0]  expRes;
    logic [15:0] expQ[$];
    guard = 0;
    while (vecDones == done0 && guard < 500) begin
      tick(1);
      guard++;
    end
    sum = 0.0;
    foreach (refQ[i]) begin
      if (!isSkip(refQ[i])) begin
        expQ.push_back(refQ[i]);
        sum = sum + fp8Val(refQ[i][15:8]) * fp8Val(refQ[i][7:0]);
      end
    end
    expRes = (expQ.size() == 0) ? 8'h00 : fp8Enc(sum);
    chk({tag, "_vec_done_count"}, 32'(vecDones - done0), 32'd1);
    chk({tag, "_mac_st_intervals"}, 32'(rises - rises0), 32'(expQ.size()));
    chk({tag, "_mac_clr_cycles"}, 32'(clrCycles - clr0), 32'd1);
    for (int i = 0; i < expQ.size() && i < issuedQ.size(); i++)
      chk($sformatf("%s_pair%0d", tag, i), 32'(issuedQ[i]), 32'(expQ[i]));
    chk({tag, "_vec_result"}, 32'(lastVec), 32'(expRes));
    tick(1);
    chk({tag, "_count_after"}, 32'(count), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_result_held"}, 32'(vec_result), 32'(expRes));
    refQ.delete();
  endtask

  initial begin
    int n;

    // reset values
    rst_n = 1'b0;
    tick(2);
    chk("rst_mac_b", 32'(mac_b), 32'd0);
    chk("rst_mac_c", 32'(mac_c), 32'd0);
    chk("rst_mac_st", 32'(mac_st), 32'd0);
    chk("rst_mac_clr", 32'(mac_clr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_vec_done", 32'(vec_done), 32'd0);
    chk("rst_vec_result", 32'(vec_result), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // 1.0 x 1.0
    writePair(8'h38, 8'h38);
    chk("one_count_loaded", 32'(count), 32'd1);
    startVec(1'b0);
    finishVec("one");

    // 2.0 + 1.0 + 1.0
    writePair(8'h38, 8'h40);
    writePair(8'h38, 8'h38);
    writePair(8'h38, 8'h38);
    startVec(1'b0);
    chk("three_busy", 32'(busy), 32'd1);
    finishVec("three");
    chk("three_is_4p0", 32'(lastVec), 32'h48);

    // empty start
    rises0 = rises;
    done0  = vecDones;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
    chk("empty_vec_done", 32'(vec_done), 32'd1);
    chk("empty_vec_result", 32'(vec_result), 32'd0);
    tick(3);
    chk("empty_done_count", 32'(vecDones - done0), 32'd1);
    chk("empty_no_mac_st", 32'(rises - rises0), 32'd0);
    chk("empty_idle", 32'(busy), 32'd0);

    // start together with wr_en: the write is dropped
    writePair(8'h38, 8'h40);
    startVec(1'b1);
    chk("start_wr_count", 32'(count), 32'd1);
    finishVec("start_wr");

    // overfill
    for (int i = 0; i < DEPTH + 2; i++) writePair(randOp(1'b1), randOp(1'b1));
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_flag", 32'(full), 32'd1);
    startVec(1'b0);
    finishVec("full");
    chk("full_flag_cleared", 32'(full), 32'd0);

    // stale done level held high before start
    writePair(randOp(1'b0), randOp(1'b0));
    writePair(randOp(1'b0), randOp(1'b0));
    forceHi = 1'b1;
    startVec(1'b0);
    tick(10);
    chk("stale_busy", 32'(busy), 32'd1);
    chk("stale_no_vec_done", 32'(vecDones - done0), 32'd0);
    chk("stale_mac_st", 32'(mac_st), 32'd1);
    chk("stale_one_interval", 32'(rises - rises0), 32'd1);
    wr_en = 1'b1;
    wr_b  = 8'h11;
    wr_c  = 8'h22;
    tick(1);
    wr_en = 1'b0;
    chk("busy_write_ignored", 32'(count), 32'd2);
    forceHi = 1'b0;
    finishVec("stale");

    // zero operand pair
    writePair(8'h00, 8'h38);
    writePair(8'h38, 8'h38);
    startVec(1'b0);
    finishVec("zskip");

    // randomized vectors
    for (int v = 0; v < 4; v++) begin
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) writePair(randOp(1'b1), randOp(1'b1));
      startVec(1'b0);
      finishVec($sformatf("rand%0d", v));
    end

    // reset while waiting for done
    writePair(8'h38, 8'h40);
    writePair(8'h38, 8'h38);
    writePair(8'h38, 8'h38);
    forceLo = 1'b1;
    startVec(1'b0);
    tick(6);
    chk("mid_mac_st_before", 32'(mac_st), 32'd1);
    chk("mid_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_mac_st_async", 32'(mac_st), 32'd0);
    chk("mid_busy_async", 32'(busy), 32'd0);
    chk("mid_count_async", 32'(count), 32'd0);
    tick(2);
    rst_n   = 1'b1;
    forceLo = 1'b0;
    tick(8);
    chk("mid_no_vec_done", 32'(vecDones - done0), 32'd0);
    refQ.delete();

    // sequencing restarts cleanly after the abort
    writePair(8'h40, 8'h40);
    writePair(8'h38, 8'h38);
    startVec(1'b0);
    finishVec("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
